// File: rtl/fpga1.sv
// fpga1: packs captured ADC blocks into 11-word checksummed frames and retransmits
// accepted receive frames addressed to the local UDP port, on one shared output stream.
module fpga1 #(
    parameter int RXDEPTH = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [255:0] adcdataout,
    input  logic [3:0]   adcexpout,
    input  logic         adcvalidout,
    input  logic         validin,
    input  logic         sof,
    input  logic         eof,
    input  logic [31:0]  datain,
    input  logic [15:0]  intudpport,
    output logic         fpga1validout,
    output logic         fpga1sof,
    output logic         fpga1eof,
    output logic [31:0]  fpga1dataout
);
    localparam int AW = (RXDEPTH > 1) ? $clog2(RXDEPTH) : 1;
    localparam int CW = $clog2(RXDEPTH + 1);
    localparam int IW = (CW > 4) ? CW : 4;

    typedef enum logic [1:0] {IDLE, TX_ADC, TX_RX, GAP} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   tx_idx_reg, idx_next;
    logic [31:0]     sum_reg, sum_next;
    logic [15:0]     seq_reg, seq_next;
    logic            valid_next, sof_next, eof_next;
    logic [31:0]     data_next;
    logic            take_adc, rx_release;

    logic            adc_pending_reg;
    logic [255:0]    pend_samp_reg, tx_samp_reg;
    logic [3:0]      pend_exp_reg, tx_exp_reg;
    logic [31:0]     samp_words [8];
    logic [2:0]      samp_sel;
    logic [31:0]     adc_word;

    logic [31:0]     rx_mem [RXDEPTH];
    logic [31:0]     rx_rd_data_reg, rx_first_reg;
    logic [AW-1:0]   rx_rd_addr, rx_wr_addr;
    logic            rx_wr_en, rx_accept, rx_start_ok, rx_room, rx_ok_now;
    logic            rx_open_reg, rx_ok_reg, rx_full_reg;
    logic [CW-1:0]   rx_cnt_reg, rx_len_reg, rx_len_next;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_samp
            assign samp_words[gi] = tx_samp_reg[32*gi +: 32];
        end
    endgenerate

    // W2 carries the top word of the block, W9 the bottom one.
    assign samp_sel = 3'(4'd9 - tx_idx_reg[3:0]);
    assign adc_word = (tx_idx_reg == IW'(1)) ? {seq_reg, 12'h000, tx_exp_reg} : samp_words[samp_sel];

    // ADC capture slot: latest block wins until its W0 goes out
    always_ff @(posedge clock) begin
        if (!reset)
            adc_pending_reg <= 1'b0;
        else if (adcvalidout)
            adc_pending_reg <= 1'b1;
        else if (take_adc)
            adc_pending_reg <= 1'b0;
    end

    always_ff @(posedge clock) begin
        if (adcvalidout) begin
            pend_samp_reg <= adcdataout;
            pend_exp_reg  <= adcexpout;
        end
        if (take_adc) begin
            tx_samp_reg <= pend_samp_reg;
            tx_exp_reg  <= pend_exp_reg;
        end
    end

    // Receive side: the port and buffer-empty test is decided on the sof word.
    always_comb begin
        rx_start_ok = (datain[31:16] == intudpport) && !rx_full_reg;
        rx_room     = rx_cnt_reg < CW'(RXDEPTH);
        rx_ok_now   = rx_ok_reg && rx_room;
        rx_wr_en    = 1'b0;
        rx_wr_addr  = '0;
        rx_accept   = 1'b0;
        rx_len_next = rx_cnt_reg + CW'(1);
        if (validin) begin
            if (sof) begin
                rx_wr_en    = rx_start_ok;
                rx_accept   = eof && rx_start_ok;
                rx_len_next = CW'(1);
            end else if (rx_open_reg) begin
                rx_wr_en   = rx_ok_now;
                rx_wr_addr = AW'(rx_cnt_reg);
                rx_accept  = eof && rx_ok_now;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_open_reg <= 1'b0;
            rx_ok_reg   <= 1'b0;
            rx_cnt_reg  <= '0;
            rx_full_reg <= 1'b0;
            rx_len_reg  <= '0;
        end else begin
            if (validin && sof) begin
                rx_open_reg <= !eof;
                rx_ok_reg   <= rx_start_ok;
                rx_cnt_reg  <= CW'(1);
            end else if (validin && rx_open_reg) begin
                if (rx_room)
                    rx_cnt_reg <= rx_cnt_reg + CW'(1);
                else
                    rx_ok_reg <= 1'b0;
                if (eof)
                    rx_open_reg <= 1'b0;
            end
            if (rx_accept) begin
                rx_full_reg <= 1'b1;
                rx_len_reg  <= rx_len_next;
            end else if (rx_release) begin
                rx_full_reg <= 1'b0;
            end
        end
    end

    // Word 0 is held in a register so a frame can start the cycle after its eof
    // without reading a RAM location written on that same edge.
    always_ff @(posedge clock) begin
        if (validin && sof && rx_start_ok)
            rx_first_reg <= datain;
    end

    assign rx_rd_addr = (state_reg == TX_RX) ? AW'(tx_idx_reg + IW'(1)) : AW'(1);

    always_ff @(posedge clock) begin
        if (rx_wr_en)
            rx_mem[rx_wr_addr] <= datain;
        rx_rd_data_reg <= rx_mem[rx_rd_addr];
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = tx_idx_reg;
        sum_next   = sum_reg;
        seq_next   = seq_reg;
        valid_next = 1'b0;
        sof_next   = 1'b0;
        eof_next   = 1'b0;
        data_next  = '0;
        take_adc   = 1'b0;
        rx_release = 1'b0;
        case (state_reg)
            IDLE: begin
                if (adc_pending_reg) begin
                    take_adc   = 1'b1;
                    valid_next = 1'b1;
                    sof_next   = 1'b1;
                    data_next  = {intudpport, 16'd44};
                    sum_next   = {intudpport, 16'd44};
                    idx_next   = IW'(1);
                    state_next = TX_ADC;
                end else if (rx_full_reg) begin
                    valid_next = 1'b1;
                    sof_next   = 1'b1;
                    data_next  = rx_first_reg;
                    idx_next   = IW'(1);
                    if (rx_len_reg == CW'(1)) begin
                        eof_next   = 1'b1;
                        rx_release = 1'b1;
                        state_next = GAP;
                    end else begin
                        state_next = TX_RX;
                    end
                end
            end
            TX_ADC: begin
                valid_next = 1'b1;
                if (tx_idx_reg == IW'(10)) begin
                    data_next  = sum_reg;
                    eof_next   = 1'b1;
                    seq_next   = seq_reg + 16'd1;
                    state_next = GAP;
                end else begin
                    data_next = adc_word;
                    sum_next  = sum_reg + adc_word;
                    idx_next  = tx_idx_reg + IW'(1);
                end
            end
            TX_RX: begin
                valid_next = 1'b1;
                data_next  = rx_rd_data_reg;
                idx_next   = tx_idx_reg + IW'(1);
                if (tx_idx_reg == IW'(rx_len_reg) - IW'(1)) begin
                    eof_next   = 1'b1;
                    rx_release = 1'b1;
                    state_next = GAP;
                end
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= IDLE;
            tx_idx_reg    <= '0;
            sum_reg       <= '0;
            seq_reg       <= '0;
            fpga1validout <= 1'b0;
            fpga1sof      <= 1'b0;
            fpga1eof      <= 1'b0;
            fpga1dataout  <= '0;
        end else begin
            state_reg     <= state_next;
            tx_idx_reg    <= idx_next;
            sum_reg       <= sum_next;
            seq_reg       <= seq_next;
            fpga1validout <= valid_next;
            fpga1sof      <= sof_next;
            fpga1eof      <= eof_next;
            fpga1dataout  <= data_next;
        end
    end
endmodule

// File: tb/tb_fpga1.sv
// Bench for fpga1: an expected-word queue model checked every cycle, plus literal pins.
module tb_fpga1;
    localparam int RXDEPTH = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [255:0] adcdataout = '0;
    logic [3:0]   adcexpout = '0;
    logic         adcvalidout = 1'b0;
    logic         validin = 1'b0;
    logic         sof = 1'b0;
    logic         eof = 1'b0;
    logic [31:0]  datain = '0;
    logic [15:0]  intudpport = 16'h1234;
    logic         fpga1validout, fpga1sof, fpga1eof;
    logic [31:0]  fpga1dataout;

    always #5 clock = ~clock;

    fpga1 #(.RXDEPTH(RXDEPTH)) dut (
        .clock(clock), .reset(reset),
        .adcdataout(adcdataout), .adcexpout(adcexpout), .adcvalidout(adcvalidout),
        .validin(validin), .sof(sof), .eof(eof), .datain(datain), .intudpport(intudpport),
        .fpga1validout(fpga1validout), .fpga1sof(fpga1sof), .fpga1eof(fpga1eof),
        .fpga1dataout(fpga1dataout)
    );

    typedef struct packed { logic s; logic e; logic [31:0] d; } word_t;
    typedef struct { int cyc; logic s; logic e; logic [31:0] d; } obs_t;

    word_t       exp_q[$];
    obs_t        obs[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    bit          prev_valid = 1'b0;
    logic [15:0] model_seq = 16'd0;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Per-cycle compare against the expected stream
    always @(negedge clock) begin
        word_t act, e;
        if (mon_en) begin
            act = {fpga1sof, fpga1eof, fpga1dataout};
            if (fpga1validout) begin
                obs.push_back('{cyc, fpga1sof, fpga1eof, fpga1dataout});
                if (fpga1sof) check("gap_before_sof", {33'd0, prev_valid}, 34'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got %h expected none", act);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_word", act, e);
                end
            end else begin
                check("idle_outputs", act, 34'd0);
            end
            prev_valid = fpga1validout;
        end
    end

    // Model: an ADC frame is header, seq/exp, top-to-bottom samples, then the sum.
    task automatic push_adc(input logic [255:0] blk, input logic [3:0] e);
        logic [31:0] w [11];
        logic [31:0] s;
        w[0] = {intudpport, 16'd44};
        w[1] = {model_seq, 12'h000, e};
        for (int j = 0; j < 8; j++) w[2+j] = blk[255-32*j -: 32];
        s = 32'd0;
        for (int j = 0; j < 10; j++) s = s + w[j];
        w[10] = s;
        for (int j = 0; j < 11; j++) exp_q.push_back({j == 0, j == 10, w[j]});
        model_seq = model_seq + 16'd1;
    endtask

    task automatic maybe_push_rx(input logic [31:0] w[$]);
        if (w[0][31:16] == intudpport && w.size() <= RXDEPTH)
            for (int j = 0; j < w.size(); j++)
                exp_q.push_back({j == 0, j == w.size() - 1, w[j]});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_word(input logic [31:0] d, input logic s, input logic e);
        validin = 1'b1; sof = s; eof = e; datain = d;
        step();
        validin = 1'b0; sof = 1'b0; eof = 1'b0; datain = '0;
    endtask

    task automatic send_rx(input logic [31:0] w[$]);
        for (int j = 0; j < w.size(); j++) drive_word(w[j], j == 0, j == w.size() - 1);
    endtask

    task automatic send_adc(input logic [255:0] blk, input logic [3:0] e);
        adcdataout = blk; adcexpout = e; adcvalidout = 1'b1;
        step();
        adcvalidout = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || fpga1validout) && t < 300) begin
            step();
            t++;
        end
        if (t >= 300) begin
            n_checks++;
            $display("FAIL %s_timeout: got %0d words pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
        step();
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] blk;
        logic [31:0]  w[$];
        int c, k, t;
        int sofs[$];

        // Reset state
        step();
        mon_en = 1'b1;
        step();
        check("rst_valid", {33'd0, fpga1validout}, 34'd0);
        check("rst_flags", {32'd0, fpga1sof, fpga1eof}, 34'd0);
        check("rst_data", {2'b0, fpga1dataout}, 34'd0);
        reset = 1'b1;
        step();

        // Single ADC block, samples 1..8 top word first, exp 4
        for (int i = 0; i < 8; i++) blk[32*i +: 32] = 32'(8 - i);
        push_adc(blk, 4'd4);
        obs.delete();
        c = cyc;
        send_adc(blk, 4'd4);
        drain("adc_single");
        check("adc_len", 34'(obs.size()), 34'd11);
        if (obs.size() == 11) begin
            check("adc_latency", 34'(obs[0].cyc), 34'(c + 2));
            check("adc_w0", {obs[0].s, obs[0].e, obs[0].d}, {2'b10, 32'h1234002C});
            check("adc_w1", {2'b0, obs[1].d}, {2'b0, 32'h00000004});
            check("adc_w2", {2'b0, obs[2].d}, 34'd1);
            check("adc_w9", {2'b0, obs[9].d}, 34'd8);
            check("adc_w10", {obs[10].s, obs[10].e, obs[10].d}, {2'b01, 32'h12340054});
        end

        reset = 1'b0;
        step();
        reset = 1'b1;
        model_seq = 16'd0;
        step();

        // Three ADC blocks 64 cycles apart
        obs.delete();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) blk[32*i +: 32] = $urandom;
            push_adc(blk, 4'hA);
            send_adc(blk, 4'hA);
            repeat (63) step();
        end
        drain("adc_three");
        sofs.delete();
        for (int i = 0; i < obs.size(); i++) if (obs[i].s) sofs.push_back(i);
        check("adc3_frames", 34'(sofs.size()), 34'd3);
        if (sofs.size() == 3) begin
            check("adc3_seq0", {2'b0, obs[sofs[0]+1].d}, {2'b0, 32'h0000000A});
            check("adc3_seq1", {2'b0, obs[sofs[1]+1].d}, {2'b0, 32'h0001000A});
            check("adc3_seq2", {2'b0, obs[sofs[2]+1].d}, {2'b0, 32'h0002000A});
            check("adc3_spacing", 34'(obs[sofs[2]].cyc - obs[sofs[1]].cyc), 34'd64);
        end

        // Accepted 4-word receive frame
        w = '{32'h1234_0000, 32'hDEADBEEF, 32'h0000_0001, 32'hCAFEF00D};
        maybe_push_rx(w);
        obs.delete();
        drive_word(w[0], 1'b1, 1'b0);
        drive_word(w[1], 1'b0, 1'b0);
        drive_word(w[2], 1'b0, 1'b0);
        c = cyc;
        drive_word(w[3], 1'b0, 1'b1);
        drain("rx4");
        check("rx4_len", 34'(obs.size()), 34'd4);
        if (obs.size() == 4) begin
            check("rx4_latency", 34'(obs[0].cyc), 34'(c + 2));
            check("rx4_first", {obs[0].s, obs[0].e, obs[0].d}, {2'b10, 32'h12340000});
            check("rx4_last", {obs[3].s, obs[3].e, obs[3].d}, {2'b01, 32'hCAFEF00D});
        end

        // Wrong port, then 17 words: both dropped
        obs.delete();
        w = '{32'h5678_0000, 32'h1, 32'h2, 32'h3};
        maybe_push_rx(w);
        send_rx(w);
        w.delete();
        for (int i = 0; i < 17; i++) w.push_back(32'h1234_0000 + 32'(i));
        maybe_push_rx(w);
        send_rx(w);
        repeat (30) step();
        check("rx_dropped", 34'(obs.size()), 34'd0);

        // Exactly RXDEPTH words is accepted
        w.delete();
        for (int i = 0; i < 16; i++) w.push_back(32'h1234_0100 + 32'(i * 3));
        maybe_push_rx(w);
        obs.delete();
        send_rx(w);
        drain("rx16");
        check("rx16_len", 34'(obs.size()), 34'd16);

        // ADC valid on the receive eof edge: ADC first, one gap, then the buffer
        for (int i = 0; i < 8; i++) blk[32*i +: 32] = 32'h0101_0101 * 32'(i + 1);
        w = '{32'h1234_00AA, 32'h0BAD_F00D, 32'h7777_7777};
        push_adc(blk, 4'h3);
        maybe_push_rx(w);
        obs.delete();
        drive_word(w[0], 1'b1, 1'b0);
        drive_word(w[1], 1'b0, 1'b0);
        adcdataout = blk; adcexpout = 4'h3; adcvalidout = 1'b1;
        drive_word(w[2], 1'b0, 1'b1);
        adcvalidout = 1'b0;
        drain("both");
        check("both_len", 34'(obs.size()), 34'd14);
        if (obs.size() == 14) begin
            check("both_adc_first", {2'b0, obs[0].d}, {2'b0, 32'h1234002C});
            check("both_gap", 34'(obs[11].cyc), 34'(obs[10].cyc + 2));
            check("both_rx_first", {obs[11].s, obs[11].e, obs[11].d}, {2'b10, 32'h123400AA});
        end

        // Stray eof, aborted frame, gaps, then a 1-word frame
        obs.delete();
        drive_word(32'h1234_AAAA, 1'b0, 1'b1);
        drive_word(32'h1234_1111, 1'b1, 1'b0);
        drive_word(32'h0000_0002, 1'b0, 1'b0);
        drive_word(32'h1234_2222, 1'b1, 1'b0);
        step();
        drive_word(32'h0000_0003, 1'b0, 1'b0);
        step();
        step();
        drive_word(32'h0000_0004, 1'b0, 1'b1);
        w = '{32'h1234_2222, 32'h0000_0003, 32'h0000_0004};
        maybe_push_rx(w);
        drain("abort");
        check("abort_len", 34'(obs.size()), 34'd3);
        obs.delete();
        w = '{32'h1234_5555};
        maybe_push_rx(w);
        drive_word(32'h1234_5555, 1'b1, 1'b1);
        drain("one_word");
        check("one_len", 34'(obs.size()), 34'd1);
        if (obs.size() == 1)
            check("one_flags", {obs[0].s, obs[0].e, obs[0].d}, {2'b11, 32'h12345555});

        // Reset during W5 of an ADC frame
        for (int i = 0; i < 8; i++) blk[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
        push_adc(blk, 4'h9);
        send_adc(blk, 4'h9);
        k = -1;
        t = 0;
        while (k != 5 && t < 40) begin
            if (fpga1validout && fpga1sof) k = 0;
            else if (fpga1validout && k >= 0) k++;
            if (k != 5) begin
                step();
                t++;
            end
        end
        check("w5_reached", 34'(k), 34'd5);
        reset = 1'b0;
        step();
        exp_q.delete();
        model_seq = 16'd0;
        check("rstmid_valid", {32'd0, fpga1validout, fpga1eof}, 34'd0);
        check("rstmid_data", {2'b0, fpga1dataout}, 34'd0);
        reset = 1'b1;
        step();
        push_adc(blk, 4'h9);
        obs.delete();
        send_adc(blk, 4'h9);
        drain("after_rst");
        check("after_rst_len", 34'(obs.size()), 34'd11);
        if (obs.size() == 11)
            check("after_rst_seq", {obs[1].s, obs[1].e, obs[1].d}, {2'b00, 32'h00000009});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
